digit_scan_display: RTL and testbench

//  Reads stored BCD digits from the digit register array and time-multiplexes them onto one

---
 rtl/digit_scan_display_pkg.sv | 21 ++
 rtl/digit_scan_display_glyph.sv | 16 +
 rtl/digit_scan_display.sv | 113 +++++++++++
 tb/tb_digit_scan_display.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_display_pkg.sv
// Shared glyph constants for the multiplexed 7-segment display path.
// Segment order is {a,b,c,d,e,f,g,dp}, active-high.
package digit_scan_display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_MASK  = 8'h01;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'b11111100,  // 0
        8'b01100000,  // 1
        8'b11011010,  // 2
        8'b11110010,  // 3
        8'b01100110,  // 4
        8'b10110110,  // 5
        8'b10111110,  // 6
        8'b11100000,  // 7
        8'b11111110,  // 8
        8'b11110110   // 9
    };

endpackage

// File: rtl/digit_scan_display_glyph.sv
// Combinational BCD to 7-segment decode; non-BCD nibbles produce a blank glyph.
module digit_glyph_decode
    import digit_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/digit_scan_display.sv
// Time-multiplexed scan of stored BCD digits onto one shared 7-segment bus, with
// per-frame input snapshot, masked entry, blanking of unentered slots and alarm blink.
module digit_scan_display
    import digit_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 4,
    parameter int BLINK_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [3:0]              digit_count,
    input  logic                    mask_en,
    input  logic                    alarm,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]            NUM_DIGITS_4 = 4'(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic                  first_q;
    logic [4*NUM_DIGITS-1:0] data_snap;
    logic [3:0]            count_snap;
    logic                  mask_snap;

    logic                  div_last;
    logic                  frame_start;
    logic [3:0]            count_sat;
    logic [3:0]            nibble;
    logic [7:0]            glyph;
    logic                  slot_lit;
    logic                  blanked;
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    digit_glyph_decode u_glyph (
        .bcd (nibble),
        .seg (glyph)
    );

    // A frame starts when the scan wraps back to slot 0, or right after reset release.
    always_comb begin
        div_last    = (div_cnt == DIV_LAST);
        frame_start = first_q | (div_last && (scan_idx == IDX_LAST));
        count_sat   = (digit_count > NUM_DIGITS_4) ? NUM_DIGITS_4 : digit_count;
        nibble      = data_snap[{scan_idx, 2'b00} +: 4];
        slot_lit    = ({{(4-IDX_W){1'b0}}, scan_idx} < count_snap);
        blanked     = alarm && !blink_phase;
        seg_next    = SEG_BLANK;
        an_next     = '0;
        if (slot_lit && !blanked) begin
            an_next  = AN_ONE << scan_idx;
            seg_next = mask_snap ? SEG_MASK : glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt     <= '0;
            scan_idx    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            first_q     <= 1'b1;
            data_snap   <= '0;
            count_snap  <= '0;
            mask_snap   <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= '0;
            frame_done  <= 1'b0;
        end else begin
            first_q <= 1'b0;
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            if (div_last) begin
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end
            if (frame_start) begin
                data_snap  <= digit_data;
                count_snap <= count_sat;
                mask_snap  <= mask_en;
            end
            frame_done <= frame_start;
            // Blink phase advances only on frame boundaries so a frame is never half-lit.
            if (!alarm) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (frame_start) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_digit_scan_display.sv
// Scoreboard bench for digit_scan_display: a time-based reference model predicts every
// output cycle; a monitor pops and compares after each rising edge.
module tb_digit_scan_display;

    localparam int N = 4;
    localparam int D = 4;
    localparam int B = 2;
    localparam int F = N * D;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digit_data;
    logic [3:0]  digit_count;
    logic        mask_en;
    logic        alarm;
    logic [7:0]  seg;
    logic [N-1:0] an;
    logic        frame_done;

    logic [12:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // reference model state
    int          k = 0;
    logic [15:0] m_data = '0;
    int          m_count = 0;
    bit          m_mask = 1'b0;
    int          run_frames = 0;

    logic [7:0] glyph_tbl [0:9] = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010,
                                    8'b01100110, 8'b10110110, 8'b10111110, 8'b11100000,
                                    8'b11111110, 8'b11110110};

    digit_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(D), .BLINK_FRAMES(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_data  (digit_data),
        .digit_count (digit_count),
        .mask_en     (mask_en),
        .alarm       (alarm),
        .seg         (seg),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Predicts outputs after the next rising edge from the inputs now applied.
    task automatic push_expected(input string nm);
        logic [7:0] e_seg;
        logic [3:0] e_an;
        logic [3:0] nib;
        bit         frame_edge;
        bit         visible;
        int         s;
        if (!rst) begin
            k = 0; m_data = '0; m_count = 0; m_mask = 1'b0; run_frames = 0;
            exp_q.push_back(13'd0);
            name_q.push_back(nm);
            return;
        end
        k++;
        s = ((k - 1) / D) % N;
        visible = !(alarm && (((run_frames / B) % 2) == 1));
        e_seg = 8'h00;
        e_an  = 4'h0;
        nib   = m_data[4*s +: 4];
        if (s < m_count && visible) begin
            e_an  = 4'(1 << s);
            e_seg = m_mask ? 8'h01 : ((nib <= 4'd9) ? glyph_tbl[nib] : 8'h00);
        end
        frame_edge = (k == 1) || (k % F == 0);
        if (frame_edge) begin
            m_data  = digit_data;
            m_count = (digit_count > N) ? N : int'(digit_count);
            m_mask  = mask_en;
        end
        if (!alarm) run_frames = 0;
        else if (frame_edge) run_frames++;
        exp_q.push_back({e_seg, e_an, frame_edge});
        name_q.push_back(nm);
    endtask

    task automatic cycle(input string nm);
        push_expected(nm);
        @(negedge clk);
    endtask

    task automatic cycles(input string nm, input int n);
        for (int i = 0; i < n; i++) cycle(nm);
    endtask

    always @(posedge clk) begin : monitor
        logic [12:0] e;
        logic [12:0] a;
        string       nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {seg, an, frame_done};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s t=%0t: seg=%b an=%b frame_done=%b, expected seg=%b an=%b frame_done=%b",
                         nm, $time, a[12:5], a[4:1], a[0], e[12:5], e[4:1], e[0]);
            end
            n_cmp++;
            if ($countones(an) > 1) begin
                n_err++;
                $display("FAIL onehot t=%0t: an=%b, expected at most one bit set", $time, an);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int len;
        int change_at;
        // reset
        rst = 1'b0; digit_data = 16'h4321; digit_count = 4'd4; mask_en = 1'b0; alarm = 1'b0;
        cycles("reset", 3);
        rst = 1'b1;
        // plain scan of 4321
        cycles("scan_4321", 48);
        // masked entry with two digits, then oversized count
        digit_count = 4'd2; mask_en = 1'b1;
        cycles("mask_count2", 40);
        digit_count = 4'd9; mask_en = 1'b0;
        cycles("count_sat", 40);
        digit_count = 4'd0;
        cycles("count_zero", 34);
        // mid-frame data change must wait for the next snapshot
        digit_data = 16'h4321; digit_count = 4'd4;
        cycles("pre_change", 20);
        change_at = $urandom_range(2, 13);
        cycles("pre_change", change_at);
        digit_data = 16'h9999;
        cycles("mid_frame_change", 40);
        // alarm blink then release
        digit_data = 16'h8765;
        alarm = 1'b1;
        cycles("alarm_blink", 10 * F);
        alarm = 1'b0;
        cycles("alarm_off", 40);
        // non-BCD nibble and reset mid-scan
        digit_data = 16'h43C1;
        cycles("non_bcd", 40);
        cycles("non_bcd", $urandom_range(1, 15));
        rst = 1'b0;
        cycle("mid_reset");
        rst = 1'b1;
        cycles("after_reset", 40);
        // randomized segments with occasional resets
        for (int sgi = 0; sgi < 60; sgi++) begin
            digit_data  = 16'($urandom);
            digit_count = 4'($urandom_range(0, 15));
            mask_en     = ($urandom_range(0, 3) == 0);
            alarm       = ($urandom_range(0, 2) == 0);
            len         = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                rst = ($urandom_range(0, 59) != 0);
                cycle("random");
            end
            rst = 1'b1;
        end
        alarm = 1'b1;
        cycles("random_alarm", 8 * F);
        alarm = 1'b0;
        cycles("drain", 3);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
